// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: blank-gap digit sequencing, double-buffered
// display value committed at frame boundaries, and optional leading-zero suppression.
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLANK_CYC  = 500,
  parameter int unsigned ON_CYC     = 49500
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic                          lz_en,
  output logic [3:0]                    num,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          load_ack,
  output logic                          frame_tick
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned MAX_CYC = (BLANK_CYC > ON_CYC) ? BLANK_CYC : ON_CYC;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_CYC - 1);
  localparam logic [TMR_W-1:0] ON_LAST    = TMR_W'(ON_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              num_q, num_d;
  logic                    ack_q, ack_d;
  logic                    tick_q, tick_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] stage_q, stage_d;
  logic                    pending_q, pending_d;
  logic                    commit;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_run;

  // Scan sequencing
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    commit  = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (timer_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          timer_d = '0;
        end
      end
      ST_SHOW: begin
        if (timer_q == ON_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          commit  = (idx_q == LAST_IDX);
        end
      end
      default: begin
        state_d = ST_BLANK;
        timer_d = '0;
      end
    endcase
  end

  // Staging and frame-boundary commit; a load in the commit cycle bypasses staging.
  always_comb begin
    stage_d   = stage_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    ack_d     = 1'b0;
    if (load) begin
      stage_d   = digits_in;
      pending_d = 1'b1;
    end
    if (commit && (pending_q || load)) begin
      disp_d    = load ? digits_in : stage_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
  end

  // A digit is suppressed when it and every more significant digit are zero.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (disp_q[4*i +: 4] == 4'h0);
      supp[i]  = lz_en && zero_run;
    end
  end

  // Outputs are registered from next-state so anode and code switch on the same edge.
  always_comb begin
    an_d  = '1;
    num_d = 4'hF;
    if (state_d == ST_SHOW) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          an_d[i] = 1'b0;
          num_d   = supp[i] ? 4'hF : disp_q[4*i +: 4];
        end
      end
    end
    tick_d = (state_d == ST_SHOW) && (timer_d == ON_LAST) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_BLANK;
      timer_q   <= '0;
      idx_q     <= '0;
      an_q      <= '1;
      num_q     <= 4'hF;
      ack_q     <= 1'b0;
      tick_q    <= 1'b0;
      disp_q    <= '1;
      stage_q   <= '1;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      num_q     <= num_d;
      ack_q     <= ack_d;
      tick_q    <= tick_d;
      disp_q    <= disp_d;
      stage_q   <= stage_d;
      pending_q <= pending_d;
    end
  end

  assign num        = num_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign load_ack   = ack_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, BLANK_CYC=2, ON_CYC=5
// (slot 7 cycles, frame 28 cycles); cycle 0 is the first cycle after reset release.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  num;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        load_ack;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  display_scan_ctrl #(.NUM_DIGITS(4), .BLANK_CYC(2), .ON_CYC(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .load      (load),
    .lz_en     (lz_en),
    .num       (num),
    .an        (an),
    .digit_idx (digit_idx),
    .load_ack  (load_ack),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] din;
    logic        lz;
    logic [3:0]  an;
    logic [3:0]  num;
    logic [1:0]  idx;
    logic        ack;
    logic        tick;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, logic ld, logic [15:0] din, logic lz, logic [3:0] a,
                              logic [3:0] n, logic [1:0] ix, logic ak, logic tk);
    vec_t v;
    v.cyc = c; v.ld = ld; v.din = din; v.lz = lz; v.an = a;
    v.num = n; v.idx = ix; v.ack = ak; v.tick = tk;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack, n_num, n_tick, tick_at;

    //              cyc ld  din    lz an    num   idx ack tick
    vecs.push_back(mk(  0, 0, 16'h0, 0, 4'hF, 4'hF, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 16'h0, 0, 4'hF, 4'hF, 0, 0, 0));
    vecs.push_back(mk(  2, 0, 16'h0, 0, 4'hE, 4'hF, 0, 0, 0));
    vecs.push_back(mk(  3, 1, 16'h1234, 0, 4'hE, 4'hF, 0, 0, 0));
    vecs.push_back(mk(  4, 0, 16'h0, 0, 4'hE, 4'hF, 0, 0, 0));
    vecs.push_back(mk(  6, 0, 16'h0, 0, 4'hE, 4'hF, 0, 0, 0));
    vecs.push_back(mk(  7, 0, 16'h0, 0, 4'hF, 4'hF, 1, 0, 0));
    vecs.push_back(mk(  9, 0, 16'h0, 0, 4'hD, 4'hF, 1, 0, 0));
    vecs.push_back(mk( 16, 0, 16'h0, 0, 4'hB, 4'hF, 2, 0, 0));
    vecs.push_back(mk( 23, 0, 16'h0, 0, 4'h7, 4'hF, 3, 0, 0));
    vecs.push_back(mk( 26, 0, 16'h0, 0, 4'h7, 4'hF, 3, 0, 0));
    vecs.push_back(mk( 27, 0, 16'h0, 0, 4'h7, 4'hF, 3, 0, 1));
    vecs.push_back(mk( 28, 0, 16'h0, 0, 4'hF, 4'hF, 0, 1, 0));
    vecs.push_back(mk( 29, 0, 16'h0, 0, 4'hF, 4'hF, 0, 0, 0));
    vecs.push_back(mk( 30, 0, 16'h0, 0, 4'hE, 4'h4, 0, 0, 0));
    vecs.push_back(mk( 39, 0, 16'h0, 0, 4'hD, 4'h3, 1, 0, 0));
    vecs.push_back(mk( 44, 0, 16'h0, 0, 4'hB, 4'h2, 2, 0, 0));
    vecs.push_back(mk( 51, 0, 16'h0, 0, 4'h7, 4'h1, 3, 0, 0));
    vecs.push_back(mk( 55, 0, 16'h0, 0, 4'h7, 4'h1, 3, 0, 1));
    vecs.push_back(mk( 56, 0, 16'h0, 0, 4'hF, 4'hF, 0, 0, 0));
    vecs.push_back(mk( 66, 1, 16'h1111, 0, 4'hD, 4'h3, 1, 0, 0));
    vecs.push_back(mk( 67, 0, 16'h0, 0, 4'hD, 4'h3, 1, 0, 0));
    vecs.push_back(mk( 76, 1, 16'h5678, 0, 4'hB, 4'h2, 2, 0, 0));
    vecs.push_back(mk( 79, 0, 16'h0, 0, 4'h7, 4'h1, 3, 0, 0));
    vecs.push_back(mk( 83, 0, 16'h0, 0, 4'h7, 4'h1, 3, 0, 1));
    vecs.push_back(mk( 84, 0, 16'h0, 0, 4'hF, 4'hF, 0, 1, 0));
    vecs.push_back(mk( 85, 0, 16'h0, 0, 4'hF, 4'hF, 0, 0, 0));
    vecs.push_back(mk( 86, 0, 16'h0, 0, 4'hE, 4'h8, 0, 0, 0));
    vecs.push_back(mk( 93, 0, 16'h0, 0, 4'hD, 4'h7, 1, 0, 0));
    vecs.push_back(mk(100, 0, 16'h0, 0, 4'hB, 4'h6, 2, 0, 0));
    vecs.push_back(mk(107, 0, 16'h0, 0, 4'h7, 4'h5, 3, 0, 0));
    vecs.push_back(mk(111, 1, 16'h0042, 1, 4'h7, 4'h5, 3, 0, 1));
    vecs.push_back(mk(112, 0, 16'h0, 1, 4'hF, 4'hF, 0, 1, 0));
    vecs.push_back(mk(114, 0, 16'h0, 1, 4'hE, 4'h2, 0, 0, 0));
    vecs.push_back(mk(121, 0, 16'h0, 1, 4'hD, 4'h4, 1, 0, 0));
    vecs.push_back(mk(128, 0, 16'h0, 1, 4'hB, 4'hF, 2, 0, 0));
    vecs.push_back(mk(135, 0, 16'h0, 1, 4'h7, 4'hF, 3, 0, 0));
    vecs.push_back(mk(139, 0, 16'h0, 1, 4'h7, 4'hF, 3, 0, 1));
    vecs.push_back(mk(140, 0, 16'h0, 0, 4'hF, 4'hF, 0, 0, 0));
    vecs.push_back(mk(142, 0, 16'h0, 0, 4'hE, 4'h2, 0, 0, 0));
    vecs.push_back(mk(149, 0, 16'h0, 0, 4'hD, 4'h4, 1, 0, 0));
    vecs.push_back(mk(156, 0, 16'h0, 0, 4'hB, 4'h0, 2, 0, 0));
    vecs.push_back(mk(163, 0, 16'h0, 0, 4'h7, 4'h0, 3, 0, 0));
    vecs.push_back(mk(167, 1, 16'h0000, 1, 4'h7, 4'h0, 3, 0, 1));
    vecs.push_back(mk(168, 0, 16'h0, 1, 4'hF, 4'hF, 0, 1, 0));
    vecs.push_back(mk(170, 0, 16'h0, 1, 4'hE, 4'h0, 0, 0, 0));
    vecs.push_back(mk(177, 0, 16'h0, 1, 4'hD, 4'hF, 1, 0, 0));
    vecs.push_back(mk(184, 0, 16'h0, 1, 4'hB, 4'hF, 2, 0, 0));
    vecs.push_back(mk(191, 0, 16'h0, 1, 4'h7, 4'hF, 3, 0, 0));
    vecs.push_back(mk(195, 1, 16'hA0B9, 1, 4'h7, 4'hF, 3, 0, 1));
    vecs.push_back(mk(196, 0, 16'h0, 1, 4'hF, 4'hF, 0, 1, 0));
    vecs.push_back(mk(198, 0, 16'h0, 1, 4'hE, 4'h9, 0, 0, 0));
    vecs.push_back(mk(205, 0, 16'h0, 1, 4'hD, 4'hB, 1, 0, 0));
    vecs.push_back(mk(212, 0, 16'h0, 1, 4'hB, 4'h0, 2, 0, 0));
    vecs.push_back(mk(219, 0, 16'h0, 1, 4'h7, 4'hA, 3, 0, 0));

    reset = 1'b1; load = 1'b0; digits_in = '0; lz_en = 1'b0;
    repeat (3) step();
    check("reset_an", 16'(an), 16'hF);
    check("reset_num", 16'(num), 16'hF);
    reset = 1'b0;
    cyc   = 0;

    foreach (vecs[k]) begin
      while (cyc < vecs[k].cyc) begin
        step();
        load = 1'b0;
      end
      load  = vecs[k].ld;
      lz_en = vecs[k].lz;
      if (vecs[k].ld) digits_in = vecs[k].din;
      check($sformatf("c%0d_an", cyc),   16'(an),         16'(vecs[k].an));
      check($sformatf("c%0d_num", cyc),  16'(num),        16'(vecs[k].num));
      check($sformatf("c%0d_idx", cyc),  16'(digit_idx),  16'(vecs[k].idx));
      check($sformatf("c%0d_ack", cyc),  16'(load_ack),   16'(vecs[k].ack));
      check($sformatf("c%0d_tick", cyc), 16'(frame_tick), 16'(vecs[k].tick));
    end

    // Mid-frame reset with a pending load: everything returns to blank at digit 0.
    while (cyc < 226) begin
      step();
      load = 1'b0;
    end
    load = 1'b1; digits_in = 16'h7777;
    step();
    load = 1'b0;
    while (cyc < 240) step();
    check("pre_rst_an", 16'(an), 16'hB);
    check("pre_rst_num", 16'(num), 16'h0);
    reset = 1'b1;
    step();
    check("rst_an", 16'(an), 16'hF);
    check("rst_num", 16'(num), 16'hF);
    check("rst_idx", 16'(digit_idx), 16'h0);
    check("rst_ack", 16'(load_ack), 16'h0);
    reset = 1'b0;
    n_ack = 0; n_num = 0; n_tick = 0; tick_at = -1;
    for (int i = 0; i < 30; i++) begin
      if (load_ack === 1'b1) n_ack++;
      if (num !== 4'hF) n_num++;
      if (frame_tick === 1'b1) begin
        n_tick++;
        tick_at = i;
      end
      step();
    end
    check("post_rst_acks", 16'(n_ack), 16'd0);
    check("post_rst_nonblank", 16'(n_num), 16'd0);
    check("post_rst_ticks", 16'(n_tick), 16'd1);
    check("post_rst_tick_cyc", 16'(tick_at), 16'd27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller that shares a single 7-segment BCD decoder (4-bit code in, active-low segments out; codes 0-9 drawn, any other code blanks) across NUM_DIGITS common-anode digits. It sequences digit selection with anti-ghosting blank gaps and double-buffers the displayed value so updates never tear mid-frame. It also offers optional leading-zero suppression. It sits between the application datapath (counters, calculators) and the shared decoder and anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant
BLANK_CYC, 500, clock cycles per slot with all anodes off (>=1)
ON_CYC, 49500, clock cycles per slot with the selected anode on (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
digits_in  input  4*NUM_DIGITS  BCD codes; digit i is at bits [4i+3:4i]
load  input  1  single-cycle strobe; captures digits_in into staging
lz_en  input  1  leading-zero suppression enable (level)
num  output  4  code to the shared decoder; 4'hF means blank
an  output  NUM_DIGITS  anode enables, active-low, at most one low
digit_idx  output  clog2(NUM_DIGITS)  index of the current slot
load_ack  output  1  one-cycle pulse when staged data is committed to display
frame_tick  output  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset). All state is registered.
- Reset values: state=BLANK, timer=0, digit_idx=0, an=all ones, num=4'hF, load_ack=0, frame_tick=0, display and staging registers=4'hF per digit, pending=0.
- FSM has two states per slot:
  - BLANK lasts BLANK_CYC cycles. an=all ones, num=4'hF.
  - SHOW lasts ON_CYC cycles. an[digit_idx]=0, num=disp[digit_idx], unless that digit is suppressed (then num=4'hF).
- A single timer counts 0..(state length-1).
  - BLANK -> SHOW when timer==BLANK_CYC-1.
  - SHOW -> BLANK when timer==ON_CYC-1. On this transition digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- Slot = BLANK_CYC+ON_CYC cycles. Frame = NUM_DIGITS slots.
- an and num are registered. They change on the same edge as the state change, so there is zero skew between anode and code.
- frame_tick=1 during the final SHOW cycle of digit NUM_DIGITS-1 (the commit cycle).
- Loading and commit:
  - load=1 writes digits_in into staging and sets pending.
  - Repeated loads before commit: last one wins.
  - Commit cycle: if pending or load, disp <= (load ? digits_in : staging), pending clears, and load_ack pulses on the next cycle.
  - A load on the commit cycle is therefore committed in that same frame boundary.
  - disp never changes at any other time.
- Leading-zero suppression (lz_en=1): digit i is blanked if disp[j]==0 for all j>=i. Digit 0 is never suppressed (value 0 shows "0"). Evaluated combinationally on disp and registered with num.
- Codes 10-15 pass through unchanged; the decoder blanks them.
- Reset asserted mid-frame: all registers return to reset values on that edge; pending data is discarded; scanning restarts at digit 0, BLANK.
- lz_en may change at any time and takes effect on the next registered num update.

Test Plan:
All tests use NUM_DIGITS=4, BLANK_CYC=2, ON_CYC=5 (slot 7 cycles, frame 28 cycles).
1. Release reset, no load -> an=4'b1111 for 2 cycles, then 4'b1110 for 5 cycles with num=4'hF. Sequence repeats through 1101, 1011, 0111. frame_tick high on cycle 27 only.
2. load with digits_in=16'h1234 in cycle 3 -> disp unchanged until commit at cycle 27; load_ack at cycle 28. Next frame shows num 4,3,2,1 with an 1110,1101,1011,0111.
3. load 16'h1111 at cycle 10, then 16'h5678 at cycle 20 -> only 5678 is committed; exactly one load_ack pulse.
4. load 16'h0042 at the commit cycle with lz_en=1 -> committed at that boundary. Following frame: num=2,4,F,F. With lz_en=0: 2,4,0,0. Value 16'h0000 with lz_en=1 -> 0,F,F,F.
5. digits_in=16'hA0B9 committed -> num sequence 9,B,0,A passed to decoder; anodes unaffected.
6. Assert reset during SHOW of digit 2 with pending=1 -> next cycle an=4'b1111, num=4'hF, digit_idx=0. No load_ack; display reverts to blank (4'hF).
